// File: rtl/decode_pkg.sv
// Shared constants for the pipelined instruction-to-state decoder:
// control-unit entry states, MIPS32 opcode/funct fields, memory size codes
// and the packed decode record that the queue stores per instruction.
package decode_pkg;

  // Control-unit entry states; ST_FETCH doubles as "not recognised"
  localparam logic [5:0] ST_FETCH = 6'd0;
  localparam logic [5:0] ST_ADDU  = 6'd6;
  localparam logic [5:0] ST_STORE = 6'd7;
  localparam logic [5:0] ST_BEQ   = 6'd11;
  localparam logic [5:0] ST_LOAD  = 6'd13;
  localparam logic [5:0] ST_SUBU  = 6'd17;
  localparam logic [5:0] ST_ADDIU = 6'd18;
  localparam logic [5:0] ST_SLTU  = 6'd19;
  localparam logic [5:0] ST_SLTIU = 6'd20;
  localparam logic [5:0] ST_CLO   = 6'd21;
  localparam logic [5:0] ST_CLZ   = 6'd22;
  localparam logic [5:0] ST_AND   = 6'd23;
  localparam logic [5:0] ST_ANDI  = 6'd24;
  localparam logic [5:0] ST_OR    = 6'd25;
  localparam logic [5:0] ST_ORI   = 6'd26;
  localparam logic [5:0] ST_XOR   = 6'd27;
  localparam logic [5:0] ST_XORI  = 6'd28;
  localparam logic [5:0] ST_NOR   = 6'd29;
  localparam logic [5:0] ST_LUI   = 6'd30;
  localparam logic [5:0] ST_SLL   = 6'd31;
  localparam logic [5:0] ST_SRA   = 6'd32;
  localparam logic [5:0] ST_SRL   = 6'd33;
  localparam logic [5:0] ST_MOVN  = 6'd34;
  localparam logic [5:0] ST_MOVZ  = 6'd35;
  localparam logic [5:0] ST_BGEZ  = 6'd37;
  localparam logic [5:0] ST_BGTZ  = 6'd39;
  localparam logic [5:0] ST_BNE   = 6'd41;
  localparam logic [5:0] ST_J     = 6'd43;
  localparam logic [5:0] ST_JAL   = 6'd44;
  localparam logic [5:0] ST_JR    = 6'd45;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_LBU      = 6'h24;
  localparam logic [5:0] OP_LHU      = 6'h25;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2B;

  // SPECIAL funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MOVZ = 6'h0A;
  localparam logic [5:0] FN_MOVN = 6'h0B;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // SPECIAL2 funct codes
  localparam logic [5:0] FN_CLZ = 6'h20;
  localparam logic [5:0] FN_CLO = 6'h21;

  // rt selectors distinguishing the branch-on-sign forms
  localparam logic [4:0] RT_BGEZ = 5'b00001;
  localparam logic [4:0] RT_BGTZ = 5'b00000;

  // Memory access size encodings
  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_WORD = 2'b11;

  // One decoded instruction as held in the queue
  typedef struct packed {
    logic [5:0] state;
    logic [1:0] mem_size;
    logic       mem_signed;
    logic       illegal;
  } decode_t;

endpackage

// File: rtl/instr_decode_comb.sv
// Pure combinational MIPS32 instruction decoder: maps an instruction word to
// its control-unit entry state, memory access size/sign and an illegal flag.
// Jump forms (J/JAL/JR) are only recognised when EXT_EN is non-zero.
module instr_decode_comb
  import decode_pkg::*;
#(
  parameter int EXT_EN = 1
) (
  input  logic [31:0] instr,
  output decode_t     dec
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [5:0] st;
  logic [1:0] size;
  logic       sgn;
  logic       unused_fields;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rt     = instr[20:16];
  assign unused_fields = ^{instr[25:21], instr[15:6]};

  // Table lookup; every legal state is non-zero, so ST_FETCH marks illegal
  always_comb begin
    st   = ST_FETCH;
    size = MEM_NONE;
    sgn  = 1'b0;
    unique case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_ADDU: st = ST_ADDU;
          FN_SUBU: st = ST_SUBU;
          FN_SLTU: st = ST_SLTU;
          FN_AND:  st = ST_AND;
          FN_OR:   st = ST_OR;
          FN_XOR:  st = ST_XOR;
          FN_NOR:  st = ST_NOR;
          FN_SLL:  st = ST_SLL;
          FN_SRA:  st = ST_SRA;
          FN_SRL:  st = ST_SRL;
          FN_MOVN: st = ST_MOVN;
          FN_MOVZ: st = ST_MOVZ;
          FN_JR:   if (EXT_EN != 0) st = ST_JR;
          default: st = ST_FETCH;
        endcase
      end
      OP_SPECIAL2: begin
        if (funct == FN_CLO) st = ST_CLO;
        else if (funct == FN_CLZ) st = ST_CLZ;
      end
      OP_REGIMM: if (rt == RT_BGEZ) st = ST_BGEZ;
      OP_BGTZ:   if (rt == RT_BGTZ) st = ST_BGTZ;
      OP_BEQ:    st = ST_BEQ;
      OP_BNE:    st = ST_BNE;
      OP_ADDIU:  st = ST_ADDIU;
      OP_SLTIU:  st = ST_SLTIU;
      OP_ANDI:   st = ST_ANDI;
      OP_ORI:    st = ST_ORI;
      OP_XORI:   st = ST_XORI;
      OP_LUI:    st = ST_LUI;
      OP_J:      if (EXT_EN != 0) st = ST_J;
      OP_JAL:    if (EXT_EN != 0) st = ST_JAL;
      OP_LB:     begin st = ST_LOAD;  size = MEM_BYTE; sgn = 1'b1; end
      OP_LH:     begin st = ST_LOAD;  size = MEM_HALF; sgn = 1'b1; end
      OP_LW:     begin st = ST_LOAD;  size = MEM_WORD; sgn = 1'b1; end
      OP_LBU:    begin st = ST_LOAD;  size = MEM_BYTE; end
      OP_LHU:    begin st = ST_LOAD;  size = MEM_HALF; end
      OP_SB:     begin st = ST_STORE; size = MEM_BYTE; end
      OP_SH:     begin st = ST_STORE; size = MEM_HALF; end
      OP_SW:     begin st = ST_STORE; size = MEM_WORD; end
      default:   st = ST_FETCH;
    endcase
  end

  assign dec.state      = st;
  assign dec.mem_size   = size;
  assign dec.mem_signed = sgn;
  assign dec.illegal    = (st == ST_FETCH);

endmodule

// File: rtl/pipelined_state_decoder.sv
// Buffered instruction-to-state decoder. Instructions are decoded as they are
// pushed and the decoded records are queued in a DEPTH-entry FIFO; the head
// record is presented to the control unit with a valid/ready handshake.
// A saturating counter tracks how many illegal instructions were accepted.
module pipelined_state_decoder
  import decode_pkg::*;
#(
  parameter int STATE_W = 7,
  parameter int DEPTH   = 4,
  parameter int EXT_EN  = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_sel,
  output logic [1:0]         mem_size,
  output logic               mem_signed,
  output logic               illegal,
  output logic [CNT_W-1:0]   illegal_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_QW = PTR_W + 1;

  decode_t           in_dec;
  decode_t           head;
  decode_t           fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_QW-1:0] count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  instr_decode_comb #(.EXT_EN(EXT_EN)) u_decode (
    .instr (instr),
    .dec   (in_dec)
  );

  assign full      = (count == CNT_QW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Queue pointers and occupancy; flush empties the queue and wins over push/pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_QW'(1);
        2'b01:   count <= count - CNT_QW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage for decoded records; contents are only observed through valid pointers
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_dec;
  end

  // Saturating count of accepted illegal instructions, survives flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_cnt <= '0;
    end else if (push && in_dec.illegal && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign head = fifo_mem[rd_ptr];

  // Head presentation, forced to zero when empty so no stale record leaks out
  always_comb begin
    state_sel  = '0;
    mem_size   = MEM_NONE;
    mem_signed = 1'b0;
    illegal    = 1'b0;
    if (!empty) begin
      state_sel  = STATE_W'(head.state);
      mem_size   = head.mem_size;
      mem_signed = head.mem_signed;
      illegal    = head.illegal;
    end
  end

endmodule
